// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: PC-mux select codes and 2-bit counter states.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        PCMUX_CURR_PC4 = 3'd0,
        PCMUX_BRANCH   = 3'd1,
        PCMUX_CORR_PC4 = 3'd2,
        PCMUX_PRED_TGT = 3'd3
    } pc_sel_e;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor; master is the pipeline, slave the predictor.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic [31:0] fetch_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    pc_sel_e     pc_sel;
    logic [31:0] predicted_target;
    logic        pred_taken;
    logic [31:0] branch;
    logic [31:0] corr_pc4;
    logic        flush;
    logic [31:0] mispredict_cnt;

    modport master (
        output fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
        input  pc_sel, predicted_target, pred_taken, branch, corr_pc4, flush, mispredict_cnt
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
        output pc_sel, predicted_target, pred_taken, branch, corr_pc4, flush, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter_2b.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter_2b
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);
    always_comb begin
        ctr_next = ctr;
        if (taken && ctr != BP_ST)
            ctr_next = ctr + 2'd1;
        else if (!taken && ctr != BP_SNT)
            ctr_next = ctr - 2'd1;
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor: same-cycle lookup for fetch, update and redirect from execute.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [ENTRIES-1:0][1:0] ctr_q, ctr_d, ctr_nxt;
    logic [TAG_BITS-1:0]     tag_q [ENTRIES];
    logic [TAG_BITS-1:0]     tag_d [ENTRIES];
    logic [31:0]             tgt_q [ENTRIES];
    logic [31:0]             tgt_d [ENTRIES];
    logic [31:0]             cnt_q, cnt_d;

    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                f_hit, u_hit, upd, mispredict;
    logic                unused_pc_lsbs;

    assign f_idx = bp.fetch_pc[IDX_BITS+1:2];
    assign f_tag = bp.fetch_pc[31:IDX_BITS+2];
    assign u_idx = bp.ex_pc[IDX_BITS+1:2];
    assign u_tag = bp.ex_pc[31:IDX_BITS+2];
    assign unused_pc_lsbs = ^bp.fetch_pc[1:0];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd   = bp.ex_valid && bp.ex_is_branch;

    // Outputs are gated by rst_n so they hold reset values while reset is asserted.
    assign mispredict = rst_n && upd && (bp.ex_taken != bp.ex_pred_taken);

    assign bp.pred_taken       = rst_n && f_hit && ctr_q[f_idx][1] && !mispredict;
    assign bp.predicted_target = f_hit ? tgt_q[f_idx] : 32'd0;
    assign bp.branch           = bp.ex_target;
    assign bp.corr_pc4         = bp.ex_pc + 32'd4;
    assign bp.flush            = mispredict;
    assign bp.mispredict_cnt   = cnt_q;

    always_comb begin
        bp.pc_sel = PCMUX_CURR_PC4;
        if (mispredict && bp.ex_taken)       bp.pc_sel = PCMUX_BRANCH;
        else if (mispredict)                 bp.pc_sel = PCMUX_CORR_PC4;
        else if (bp.pred_taken)              bp.pc_sel = PCMUX_PRED_TGT;
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        sat_counter_2b u_ctr (
            .ctr      (ctr_q[i]),
            .taken    (bp.ex_taken),
            .ctr_next (ctr_nxt[i])
        );
    end

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q + 32'(mispredict);
        if (upd) begin
            if (u_hit) begin
                ctr_d[u_idx] = ctr_nxt[u_idx];
                if (bp.ex_taken) tgt_d[u_idx] = bp.ex_target;
            end else if (bp.ex_taken) begin
                // Allocation unconditionally evicts whatever aliased into this slot.
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = bp.ex_target;
                ctr_d[u_idx]   = BP_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{BP_WNT}};
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table plus randomized run against a behavioural BTB model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_if bpi ();

    branch_predictor #(.IDX_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bpi.slave)
    );

    typedef struct {
        logic [31:0] fetch_pc;
        logic        exv, exb;
        logic [31:0] ex_pc;
        logic        ext;
        logic [31:0] ex_tgt;
        logic        expred;
        logic [2:0]  e_sel;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_flush;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: each slot remembers the full pc that owns it and an integer confidence.
    bit          m_valid [16];
    logic [31:0] m_pc    [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bpi.fetch_pc      = v.fetch_pc;
        bpi.ex_valid      = v.exv;
        bpi.ex_is_branch  = v.exb;
        bpi.ex_pc         = v.ex_pc;
        bpi.ex_taken      = v.ext;
        bpi.ex_target     = v.ex_tgt;
        bpi.ex_pred_taken = v.expred;
    endtask

    function automatic vec_t mk(logic [31:0] f, logic v, logic b, logic [31:0] p, logic t,
                                logic [31:0] g, logic pr, pc_sel_e s, logic pt,
                                logic [31:0] et, logic fl, logic [31:0] c);
        vec_t r;
        r.fetch_pc = f; r.exv = v; r.exb = b; r.ex_pc = p; r.ext = t; r.ex_tgt = g;
        r.expred = pr; r.e_sel = s; r.e_pt = pt; r.e_tgt = et; r.e_flush = fl; r.e_cnt = c;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_cnt = 0;
    endfunction

    function automatic int midx(logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit mhit(logic [31:0] pc);
        int i = midx(pc);
        return m_valid[i] && ((m_pc[i] >> 6) == (pc >> 6));
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        p = 32'h1000 + 32'($urandom_range(0, 2)) * 64 + 32'($urandom_range(0, 3)) * 4;
        return p;
    endfunction

    initial begin
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, PCMUX_CURR_PC4, 0, 0, 0, 0);
        rst_n = 1'b0;
        drive(z);
        // Reset held with a mispredicting resolve on the inputs: outputs must stay quiet.
        bpi.fetch_pc = 32'h100; bpi.ex_valid = 1; bpi.ex_is_branch = 1; bpi.ex_taken = 1;
        #3;
        chk("rst_pc_sel", 32'(bpi.pc_sel), 32'(PCMUX_CURR_PC4));
        chk("rst_flush", 32'(bpi.flush), 0);
        chk("rst_pred_taken", 32'(bpi.pred_taken), 0);
        chk("rst_cnt", bpi.mispredict_cnt, 0);
        drive(z);
        #9 rst_n = 1'b1;

        tbl.push_back(mk(32'h100, 0, 0, 0,      0, 0,      0, PCMUX_CURR_PC4, 0, 0,      0, 0));
        tbl.push_back(mk(32'h104, 1, 1, 32'h100, 1, 32'h200, 0, PCMUX_BRANCH,  0, 0,      1, 0));
        tbl.push_back(mk(32'h100, 0, 0, 0,      0, 0,      0, PCMUX_PRED_TGT, 1, 32'h200, 0, 1));
        tbl.push_back(mk(32'h104, 1, 1, 32'h100, 0, 0,      1, PCMUX_CORR_PC4, 0, 0,      1, 1));
        tbl.push_back(mk(32'h100, 0, 0, 0,      0, 0,      0, PCMUX_CURR_PC4, 0, 32'h200, 0, 2));
        tbl.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h200, 1, PCMUX_CURR_PC4, 0, 32'h200, 0, 2));
        tbl.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h200, 1, PCMUX_PRED_TGT, 1, 32'h200, 0, 2));
        tbl.push_back(mk(32'h104, 1, 1, 32'h100, 1, 32'h200, 1, PCMUX_CURR_PC4, 0, 0,      0, 2));
        tbl.push_back(mk(32'h104, 1, 1, 32'h100, 1, 32'h200, 1, PCMUX_CURR_PC4, 0, 0,      0, 2));
        tbl.push_back(mk(32'h104, 1, 1, 32'h100, 0, 0,      1, PCMUX_CORR_PC4, 0, 0,      1, 2));
        tbl.push_back(mk(32'h100, 0, 0, 0,      0, 0,      0, PCMUX_PRED_TGT, 1, 32'h200, 0, 3));
        tbl.push_back(mk(32'h104, 1, 1, 32'h140, 1, 32'h500, 0, PCMUX_BRANCH,  0, 0,      1, 3));
        tbl.push_back(mk(32'h100, 0, 0, 0,      0, 0,      0, PCMUX_CURR_PC4, 0, 0,      0, 4));
        tbl.push_back(mk(32'h140, 0, 0, 0,      0, 0,      0, PCMUX_PRED_TGT, 1, 32'h500, 0, 4));
        tbl.push_back(mk(32'h140, 1, 1, 32'h108, 1, 32'h600, 0, PCMUX_BRANCH,  0, 32'h500, 1, 4));
        tbl.push_back(mk(32'h140, 1, 0, 32'h140, 0, 0,      1, PCMUX_PRED_TGT, 1, 32'h500, 0, 5));
        tbl.push_back(mk(32'h140, 0, 0, 0,      0, 0,      0, PCMUX_PRED_TGT, 1, 32'h500, 0, 5));
        tbl.push_back(mk(32'h140, 1, 1, 32'h180, 0, 0,      1, PCMUX_CORR_PC4, 0, 32'h500, 1, 5));
        tbl.push_back(mk(32'h140, 0, 0, 0,      0, 0,      0, PCMUX_PRED_TGT, 1, 32'h500, 0, 6));

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            drive(tbl[k]);
            @(negedge clk);
            chk($sformatf("v%0d_pc_sel", k), 32'(bpi.pc_sel), 32'(tbl[k].e_sel));
            chk($sformatf("v%0d_pred_taken", k), 32'(bpi.pred_taken), 32'(tbl[k].e_pt));
            chk($sformatf("v%0d_pred_tgt", k), bpi.predicted_target, tbl[k].e_tgt);
            chk($sformatf("v%0d_flush", k), 32'(bpi.flush), 32'(tbl[k].e_flush));
            chk($sformatf("v%0d_cnt", k), bpi.mispredict_cnt, tbl[k].e_cnt);
        end
        chk("v1_branch_vs_row", 32'h200, tbl[1].ex_tgt);

        // Explicit redirect values from a lone mispredict.
        @(posedge clk); #1;
        drive(mk(32'h104, 1, 1, 32'h100, 0, 32'h777, 1, PCMUX_CORR_PC4, 0, 0, 1, 6));
        @(negedge clk);
        chk("corr_pc4_0x100", bpi.corr_pc4, 32'h104);
        chk("branch_0x777", bpi.branch, 32'h777);

        // Asynchronous reset between edges, with a live mispredict on the inputs.
        @(posedge clk); #1;
        drive(mk(32'h140, 1, 1, 32'h108, 1, 32'h600, 0, PCMUX_BRANCH, 0, 0, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc_sel", 32'(bpi.pc_sel), 32'(PCMUX_CURR_PC4));
        chk("async_rst_flush", 32'(bpi.flush), 0);
        chk("async_rst_pred", 32'(bpi.pred_taken), 0);
        chk("async_rst_tgt", bpi.predicted_target, 0);
        chk("async_rst_cnt", bpi.mispredict_cnt, 0);
        drive(z);
        @(negedge clk);
        rst_n = 1'b1;
        bpi.fetch_pc = 32'h140;
        @(posedge clk); #1;
        chk("cold_after_rst_sel", 32'(bpi.pc_sel), 32'(PCMUX_CURR_PC4));
        chk("cold_after_rst_tgt", bpi.predicted_target, 0);

        // Randomized phase against the behavioural model.
        model_reset();
        for (int n = 0; n < 400; n++) begin
            vec_t r;
            int   i;
            bit   mp, h, pt;
            logic [2:0] esel;
            @(posedge clk); #1;
            r = z;
            r.fetch_pc = rand_pc();
            r.exv      = ($urandom_range(0, 3) != 0);
            r.exb      = ($urandom_range(0, 7) != 0);
            r.ex_pc    = rand_pc();
            r.ext      = 1'($urandom_range(0, 1));
            r.ex_tgt   = $urandom & 32'hFFFF_FFFC;
            r.expred   = 1'($urandom_range(0, 1));
            drive(r);
            @(negedge clk);

            mp = r.exv && r.exb && (r.ext != r.expred);
            h  = mhit(r.fetch_pc);
            pt = h && m_ctr[midx(r.fetch_pc)] >= 2 && !mp;
            if (mp) esel = r.ext ? PCMUX_BRANCH : PCMUX_CORR_PC4;
            else    esel = pt ? PCMUX_PRED_TGT : PCMUX_CURR_PC4;
            chk("rnd_pc_sel", 32'(bpi.pc_sel), 32'(esel));
            chk("rnd_pred_taken", 32'(bpi.pred_taken), 32'(pt));
            chk("rnd_pred_tgt", bpi.predicted_target, h ? m_tgt[midx(r.fetch_pc)] : 32'd0);
            chk("rnd_flush", 32'(bpi.flush), 32'(mp));
            chk("rnd_branch", bpi.branch, r.ex_tgt);
            chk("rnd_corr_pc4", bpi.corr_pc4, r.ex_pc + 32'd4);
            chk("rnd_cnt", bpi.mispredict_cnt, m_cnt);

            if (mp) m_cnt = m_cnt + 1;
            if (r.exv && r.exb) begin
                i = midx(r.ex_pc);
                if (mhit(r.ex_pc)) begin
                    if (r.ext) begin
                        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_tgt[i] = r.ex_tgt;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (r.ext) begin
                    m_valid[i] = 1;
                    m_pc[i]    = r.ex_pc;
                    m_tgt[i]   = r.ex_tgt;
                    m_ctr[i]   = 2;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
